// File: rtl/command_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : command_pkg
// Description : Shared command field widths, command record and the
//               command-kind encoding used by command_queue and the core.
// Revision    : 1.0 - initial release
// ============================================================================
package command_pkg;

    localparam int KIND_W = 3;
    localparam int OP1_W  = 4;
    localparam int OP2_W  = 8;

    typedef enum logic [KIND_W-1:0] {
        CMD_NOP   = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STORE = 3'd2,
        CMD_ADD   = 3'd3,
        CMD_SUB   = 3'd4,
        CMD_AND   = 3'd5,
        CMD_OR    = 3'd6,
        CMD_HALT  = 3'd7
    } kind_e;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [OP1_W-1:0]  op1;
        logic [OP2_W-1:0]  op2;
    } command_t;

endpackage
`default_nettype wire

// File: rtl/command_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : command_queue_if
// Description : Pin-side command capture and core-side valid/ready bundle
//               for command_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface command_queue_if #(
    parameter int DEPTH  = 4,
    parameter int KIND_W = command_pkg::KIND_W,
    parameter int OP1_W  = command_pkg::OP1_W,
    parameter int OP2_W  = command_pkg::OP2_W
) ();

    logic                     in_strobe;
    logic [KIND_W-1:0]        in_kind;
    logic [OP1_W-1:0]         in_op1;
    logic [OP2_W-1:0]         in_op2;
    logic                     out_valid;
    logic                     out_ready;
    logic [KIND_W-1:0]        out_kind;
    logic [OP1_W-1:0]         out_op1;
    logic [OP2_W-1:0]         out_op2;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     overflow;
    logic                     clear_overflow;

    modport master (
        output in_strobe, in_kind, in_op1, in_op2, out_ready, clear_overflow,
        input  out_valid, out_kind, out_op1, out_op2, count, full, overflow
    );

    modport slave (
        input  in_strobe, in_kind, in_op1, in_op2, out_ready, clear_overflow,
        output out_valid, out_kind, out_op1, out_op2, count, full, overflow
    );

endinterface
`default_nettype wire

// File: rtl/command_queue_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : strobe_sync
// Description : Two-flop synchronizer plus rising-edge detector; emits a
//               one-cycle push_pulse per low-to-high strobe transition.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_strobe,
    output logic      push_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_strobe;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign push_pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/command_queue.sv
`default_nettype none
// ============================================================================
// Module      : command_queue
// Description : Pin-strobed command capture FIFO feeding the core over
//               valid/ready. COMMAND_QUEUE_SYNC_EN selects an asynchronous,
//               edge-detected strobe instead of a synchronous valid level.
// Revision    : 1.0 - initial release
// ============================================================================
module command_queue #(
    parameter int DEPTH  = 4,
    parameter int KIND_W = command_pkg::KIND_W,
    parameter int OP1_W  = command_pkg::OP1_W,
    parameter int OP2_W  = command_pkg::OP2_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    command_queue_if.slave   bus
);

    import command_pkg::*;

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    command_t           r_mem [DEPTH];

    command_t           w_in_cmd;
    command_t           w_push_cmd;
    command_t           w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    logic               w_drop;

    assign w_in_cmd.kind = bus.in_kind;
    assign w_in_cmd.op1  = bus.in_op1;
    assign w_in_cmd.op2  = bus.in_op2;

`ifdef COMMAND_QUEUE_SYNC_EN
    logic     w_strobe_pulse;
    logic     r_pend_valid;
    command_t r_pend_cmd;

    strobe_sync u_strobe_sync (
        .clk        (clk),
        .rst        (rst),
        .i_strobe   (bus.in_strobe),
        .push_pulse (w_strobe_pulse)
    );

    // Pins are captured when the edge is detected; the FIFO write follows one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= '0;
        end else begin
            r_pend_valid <= w_strobe_pulse;
            if (w_strobe_pulse) begin
                r_pend_cmd <= w_in_cmd;
            end
        end
    end

    assign w_push     = r_pend_valid;
    assign w_push_cmd = r_pend_cmd;
`else
    assign w_push     = bus.in_strobe;
    assign w_push_cmd = w_in_cmd;
`endif

    assign w_full  = (r_count == c_FULL);
    assign w_pop   = (r_count != '0) && bus.out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_write = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_push_cmd;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.out_kind  = KIND_W'(w_head.kind);
    assign bus.out_op1   = OP1_W'(w_head.op1);
    assign bus.out_op2   = OP2_W'(w_head.op2);
    assign bus.out_valid = (r_count != '0);
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire
